// File: rtl/imem_pkg.sv
// rtl/imem_pkg.sv - shared state encoding and sizing constants for the instruction memory loader
package imem_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RECV  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } imem_state_t;

  localparam int BYTES_PER_WORD = 4;
  localparam int DEFAULT_DEPTH  = 1024;

endpackage

// File: rtl/imem_loader_if.sv
// rtl/imem_loader_if.sv - host/loader bus: control, byte stream, memory write port and status
// Purpose: bundles every non-clock signal of the loader.
// Ports (signals):
//   start, num_words, abort          host -> loader control
//   byte_valid, byte_data            host -> loader byte stream
//   byte_ready                       loader -> host byte stream
//   wr_en, wr_addr, wr_data          loader -> instruction memory
//   cpu_hold, busy, done, err, checksum  loader status
// Modports: master = host/bench side, slave = loader side.
interface imem_loader_if #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int INSTR_WIDTH   = 32
);
  logic                     start;
  logic [ADDRESS_WIDTH-1:0] num_words;
  logic                     abort;
  logic                     byte_valid;
  logic [7:0]               byte_data;
  logic                     byte_ready;
  logic                     wr_en;
  logic [ADDRESS_WIDTH-1:0] wr_addr;
  logic [INSTR_WIDTH-1:0]   wr_data;
  logic                     cpu_hold;
  logic                     busy;
  logic                     done;
  logic                     err;
  logic [INSTR_WIDTH-1:0]   checksum;

  modport master (
    output start, num_words, abort, byte_valid, byte_data,
    input  byte_ready, wr_en, wr_addr, wr_data, cpu_hold, busy, done, err, checksum
  );

  modport slave (
    input  start, num_words, abort, byte_valid, byte_data,
    output byte_ready, wr_en, wr_addr, wr_data, cpu_hold, busy, done, err, checksum
  );
endinterface

// File: rtl/imem_byte_packer.sv
// rtl/imem_byte_packer.sv - big-endian byte-to-word shift register with byte counter
// Purpose: shifts accepted bytes into a word, first byte ends up in the MSBs.
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   i_clear       synchronous clear of word and byte counter
//   i_valid       a byte transfers this cycle
//   i_data        byte value
//   o_word        packed word (registered)
//   o_word_full   this transfer is the last byte of the word
module imem_byte_packer
  import imem_pkg::*;
#(
  parameter int INSTR_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_clear,
  input  logic                   i_valid,
  input  logic [7:0]             i_data,
  output logic [INSTR_WIDTH-1:0] o_word,
  output logic                   o_word_full
);

  logic [INSTR_WIDTH-1:0] r_word;
  logic [1:0]             r_cnt;

  assign o_word      = r_word;
  assign o_word_full = i_valid && (r_cnt == 2'(BYTES_PER_WORD - 1));

  // Counter wraps naturally from 3 to 0, so the next word starts clean.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_word <= '0;
      r_cnt  <= '0;
    end else if (i_clear) begin
      r_word <= '0;
      r_cnt  <= '0;
    end else if (i_valid) begin
      r_word <= {r_word[INSTR_WIDTH-9:0], i_data};
      r_cnt  <= r_cnt + 2'd1;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - loads a byte-streamed program into instruction memory, stalling the CPU
// Purpose: FSM, word/address counters and running XOR checksum; packs bytes
//   via imem_byte_packer and issues one word-aligned write per word.
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   bus           imem_loader_if.slave (control, byte stream, write port, status)
// INSTR_WIDTH must be 32 (four bytes per word).
module imem_loader
  import imem_pkg::*;
#(
  parameter int                         ADDRESS_WIDTH = 32,
  parameter int                         INSTR_WIDTH   = 32,
  parameter int                         DEPTH         = DEFAULT_DEPTH,
  parameter logic [ADDRESS_WIDTH-1:0]   BASE_ADDR     = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  imem_loader_if.slave  bus
);

  imem_state_t              r_state, w_next_state;
  logic [ADDRESS_WIDTH-1:0] r_num_words;
  logic [ADDRESS_WIDTH-1:0] r_word_cnt;
  logic [ADDRESS_WIDTH-1:0] r_wr_addr;
  logic [INSTR_WIDTH-1:0]   r_checksum;
  logic                     r_wr_en, r_done, r_err, r_hold;

  logic                     w_byte_ready, w_xfer, w_word_full;
  logic                     w_len_ok, w_start_ok, w_start_bad, w_last_word;
  logic [INSTR_WIDTH-1:0]   w_word;

  // byte_ready decodes from state only: no path from byte_valid to it.
  assign w_byte_ready = (r_state == S_RECV);
  assign w_xfer       = bus.byte_valid && w_byte_ready;

  assign w_len_ok    = (bus.num_words != '0) &&
                       (bus.num_words <= ADDRESS_WIDTH'(DEPTH));
  assign w_start_ok  = (r_state == S_IDLE) && bus.start && w_len_ok;
  assign w_start_bad = (r_state == S_IDLE) && bus.start && !w_len_ok;
  assign w_last_word = ((r_word_cnt + ADDRESS_WIDTH'(1)) == r_num_words);

  imem_byte_packer #(
    .INSTR_WIDTH (INSTR_WIDTH)
  ) u_packer (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_clear     (w_start_ok),
    .i_valid     (w_xfer),
    .i_data      (bus.byte_data),
    .o_word      (w_word),
    .o_word_full (w_word_full)
  );

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (w_start_ok) w_next_state = S_RECV;
      // Abort wins over a completing word: the 4th byte is dropped.
      S_RECV:  if (bus.abort)       w_next_state = S_IDLE;
               else if (w_word_full) w_next_state = S_WRITE;
      S_WRITE: if (bus.abort)       w_next_state = S_IDLE;
               else if (w_last_word) w_next_state = S_DONE;
               else                  w_next_state = S_RECV;
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Status outputs are registered from next state so they line up with state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_wr_en     <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_hold      <= 1'b0;
      r_num_words <= '0;
      r_word_cnt  <= '0;
      r_wr_addr   <= '0;
      r_checksum  <= '0;
    end else begin
      r_state <= w_next_state;
      r_wr_en <= (w_next_state == S_WRITE);
      r_done  <= (w_next_state == S_DONE);
      r_hold  <= (w_next_state != S_IDLE);
      r_err   <= w_start_bad || ((r_state != S_IDLE) && bus.abort);
      if (w_start_ok) begin
        r_num_words <= bus.num_words;
        r_word_cnt  <= '0;
        r_wr_addr   <= BASE_ADDR;
        r_checksum  <= '0;
      end else if (r_state == S_WRITE) begin
        r_checksum  <= r_checksum ^ w_word;
        r_wr_addr   <= r_wr_addr + ADDRESS_WIDTH'(4);
        r_word_cnt  <= r_word_cnt + ADDRESS_WIDTH'(1);
      end
    end
  end

  assign bus.byte_ready = w_byte_ready;
  assign bus.wr_en      = r_wr_en;
  assign bus.wr_addr    = r_wr_addr;
  assign bus.wr_data    = w_word;
  assign bus.cpu_hold   = r_hold;
  assign bus.busy       = r_hold;
  assign bus.done       = r_done;
  assign bus.err        = r_err;
  assign bus.checksum   = r_checksum;

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - directed self-checking bench for imem_loader
module tb_imem_loader;

  logic clk;
  logic rst_n;

  imem_loader_if bus ();

  imem_loader dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] q_addr[$];
  logic [31:0] q_data[$];
  int          n_done = 0;
  int          n_errp = 0;

  always @(negedge clk) begin
    if (bus.wr_en) begin
      q_addr.push_back(bus.wr_addr);
      q_data.push_back(bus.wr_data);
    end
    if (bus.done) n_done++;
    if (bus.err)  n_errp++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    q_addr.delete();
    q_data.delete();
    n_done = 0;
    n_errp = 0;
  endtask

  task automatic start_load(input logic [31:0] n);
    bus.num_words = n;
    bus.start     = 1'b1;
    tick();
    bus.start     = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int   k;
    logic rdy;
    bus.byte_valid = 1'b1;
    bus.byte_data  = b;
    k = 0;
    do begin
      @(negedge clk);
      rdy = bus.byte_ready;
      tick();
      k++;
    end while (!rdy && k < 50);
    if (!rdy) check_eq("byte_timeout", 32'(rdy), 32'd1);
    bus.byte_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int b = 0; b < 4; b++) send_byte(w[31-8*b -: 8]);
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (bus.busy && k < 100) begin
      tick();
      k++;
    end
    if (bus.busy) check_eq("idle_timeout", 32'(bus.busy), 32'd0);
    tick();
  endtask

  task automatic check_outputs_zero(input string tag);
    check_eq({tag, "_ready"}, 32'(bus.byte_ready), 32'd0);
    check_eq({tag, "_wren"},  32'(bus.wr_en),      32'd0);
    check_eq({tag, "_addr"},  bus.wr_addr,         32'd0);
    check_eq({tag, "_data"},  bus.wr_data,         32'd0);
    check_eq({tag, "_hold"},  32'(bus.cpu_hold),   32'd0);
    check_eq({tag, "_busy"},  32'(bus.busy),       32'd0);
    check_eq({tag, "_done"},  32'(bus.done),       32'd0);
    check_eq({tag, "_err"},   32'(bus.err),        32'd0);
    check_eq({tag, "_csum"},  bus.checksum,        32'd0);
  endtask

  logic [31:0] exp_w[16];
  logic [31:0] exp_csum;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n          = 1'b0;
    bus.start      = 1'b0;
    bus.num_words  = '0;
    bus.abort      = 1'b0;
    bus.byte_valid = 1'b0;
    bus.byte_data  = '0;
    repeat (3) tick();
    check_outputs_zero("rst");
    rst_n = 1'b1;
    tick();

    // 1: two-word load
    clear_log();
    start_load(32'd2);
    check_eq("t1_busy", 32'(bus.busy), 32'd1);
    check_eq("t1_hold", 32'(bus.cpu_hold), 32'd1);
    send_word(32'h8C010004);
    send_word(32'h20420001);
    wait_idle();
    check_eq("t1_nwr", q_addr.size(), 32'd2);
    if (q_addr.size() == 2) begin
      check_eq("t1_a0", q_addr[0], 32'h0);
      check_eq("t1_d0", q_data[0], 32'h8C010004);
      check_eq("t1_a1", q_addr[1], 32'h4);
      check_eq("t1_d1", q_data[1], 32'h20420001);
    end
    check_eq("t1_done", n_done, 32'd1);
    check_eq("t1_csum", bus.checksum, 32'hAC430005);
    check_eq("t1_addr", bus.wr_addr, 32'h8);
    check_eq("t1_hold_off", 32'(bus.cpu_hold), 32'd0);

    // 2: bad lengths, then the largest legal length aborted straight away
    clear_log();
    start_load(32'd0);
    check_eq("t2_err0", 32'(bus.err), 32'd1);
    check_eq("t2_busy0", 32'(bus.busy), 32'd0);
    tick();
    check_eq("t2_err0_off", 32'(bus.err), 32'd0);
    start_load(32'd1025);
    check_eq("t2_err1025", 32'(bus.err), 32'd1);
    check_eq("t2_busy1025", 32'(bus.busy), 32'd0);
    tick();
    check_eq("t2_nerr", n_errp, 32'd2);
    start_load(32'd1024);
    check_eq("t2_busy1024", 32'(bus.busy), 32'd1);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    check_eq("t2_abort_err", 32'(bus.err), 32'd1);
    check_eq("t2_abort_busy", 32'(bus.busy), 32'd0);
    check_eq("t2_nwr", q_addr.size(), 32'd0);

    // 3: sixteen words with random gaps
    clear_log();
    exp_csum = '0;
    for (int i = 0; i < 16; i++) begin
      exp_w[i] = $urandom;
      exp_csum = exp_csum ^ exp_w[i];
    end
    start_load(32'd16);
    for (int i = 0; i < 16; i++) begin
      for (int b = 0; b < 4; b++) begin
        send_byte(exp_w[i][31-8*b -: 8]);
        repeat ($urandom_range(0, 3)) tick();
      end
    end
    wait_idle();
    check_eq("t3_nwr", q_addr.size(), 32'd16);
    if (q_addr.size() == 16) begin
      for (int i = 0; i < 16; i++) begin
        check_eq($sformatf("t3_a%0d", i), q_addr[i], 32'(i * 4));
        check_eq($sformatf("t3_d%0d", i), q_data[i], exp_w[i]);
      end
    end
    check_eq("t3_csum", bus.checksum, exp_csum);
    check_eq("t3_done", n_done, 32'd1);

    // 4: abort after six bytes of a three-word load
    clear_log();
    start_load(32'd3);
    send_word(32'h11223344);
    send_byte(8'h55);
    send_byte(8'h66);
    check_eq("t4_hold_pre", 32'(bus.cpu_hold), 32'd1);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    check_eq("t4_err", 32'(bus.err), 32'd1);
    check_eq("t4_hold", 32'(bus.cpu_hold), 32'd0);
    check_eq("t4_busy", 32'(bus.busy), 32'd0);
    check_eq("t4_ready", 32'(bus.byte_ready), 32'd0);
    repeat (3) tick();
    check_eq("t4_nwr", q_addr.size(), 32'd1);
    if (q_addr.size() == 1) check_eq("t4_d0", q_data[0], 32'h11223344);
    check_eq("t4_nerr", n_errp, 32'd1);

    // 4b: abort on the same cycle as the 4th byte drops the write
    clear_log();
    start_load(32'd1);
    send_byte(8'hA1);
    send_byte(8'hA2);
    send_byte(8'hA3);
    bus.byte_valid = 1'b1;
    bus.byte_data  = 8'hA4;
    bus.abort      = 1'b1;
    tick();
    bus.byte_valid = 1'b0;
    bus.abort      = 1'b0;
    repeat (3) tick();
    check_eq("t4b_nwr", q_addr.size(), 32'd0);
    check_eq("t4b_nerr", n_errp, 32'd1);
    check_eq("t4b_busy", 32'(bus.busy), 32'd0);

    // 5: asynchronous reset in the middle of the second word
    clear_log();
    start_load(32'd2);
    send_word(32'hDEADBEEF);
    send_byte(8'h01);
    send_byte(8'h02);
    check_eq("t5_csum_pre", bus.checksum, 32'hDEADBEEF);
    #3;
    rst_n = 1'b0;
    #1;
    check_outputs_zero("t5_async");
    tick();
    rst_n = 1'b1;
    tick();
    clear_log();
    start_load(32'd1);
    send_word(32'hAABBCCDD);
    wait_idle();
    check_eq("t5_nwr", q_addr.size(), 32'd1);
    if (q_addr.size() == 1) begin
      check_eq("t5_a0", q_addr[0], 32'h0);
      check_eq("t5_d0", q_data[0], 32'hAABBCCDD);
    end
    check_eq("t5_csum", bus.checksum, 32'hAABBCCDD);

    // 6: start during RECV is ignored
    clear_log();
    start_load(32'd2);
    send_byte(8'h10);
    send_byte(8'h20);
    start_load(32'd5);
    check_eq("t6_err", 32'(bus.err), 32'd0);
    send_byte(8'h30);
    send_byte(8'h40);
    send_word(32'h50607080);
    wait_idle();
    repeat (10) tick();
    check_eq("t6_nwr", q_addr.size(), 32'd2);
    if (q_addr.size() == 2) begin
      check_eq("t6_d0", q_data[0], 32'h10203040);
      check_eq("t6_d1", q_data[1], 32'h50607080);
    end
    check_eq("t6_done", n_done, 32'd1);
    check_eq("t6_busy", 32'(bus.busy), 32'd0);
    check_eq("t6_csum", bus.checksum, 32'h404040C0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
